// File: rtl/wb_pkg.sv
// Shared defaults, address-width derivation and arbiter FSM encoding for the
// register-bank write-port arbiter.
package wb_pkg;
  localparam int DEF_NUMREGS   = 32;
  localparam int DEF_DATAWIDTH = 32;

  // Request/grant bit positions inside the 2-source vectors.
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;

  // One extra bit so out-of-range register numbers pass through untouched.
  function automatic int calc_aw(input int numregs);
    return $clog2(numregs) + 1;
  endfunction

  localparam int DEF_AW = calc_aw(DEF_NUMREGS);

  typedef enum logic {
    NORM  = 1'b0,
    BOOST = 1'b1
  } arb_state_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// ALU/LSU result offers and the register-bank write port of the arbiter.
interface wb_arbiter_if #(
  parameter int AW        = 6,
  parameter int DATAWIDTH = 32
);
  logic                 alu_valid_i;
  logic [AW-1:0]        alu_rd_i;
  logic [DATAWIDTH-1:0] alu_data_i;
  logic                 alu_ready_o;
  logic                 lsu_valid_i;
  logic [AW-1:0]        lsu_rd_i;
  logic [DATAWIDTH-1:0] lsu_data_i;
  logic                 lsu_ready_o;
  logic                 we_o;
  logic [AW-1:0]        waddr_o;
  logic [DATAWIDTH-1:0] wdata_o;
  logic                 starved_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output alu_ready_o, lsu_ready_o,
    output we_o, waddr_o, wdata_o, starved_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  alu_ready_o, lsu_ready_o,
    input  we_o, waddr_o, wdata_o, starved_o
  );
endinterface

// File: rtl/wb_prio_arb2.sv
// Two-source priority arbiter: LSU wins normally, ALU gets a one-cycle boost
// after STARVE_LIMIT consecutive lost arbitrations.
module wb_prio_arb2
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       starved
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORM;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign cnt_inc = (cnt == LIM) ? cnt : cnt + 1'b1;
  assign starved = (state == BOOST);

  always_comb begin
    gnt     = '0;
    state_n = state;
    cnt_n   = cnt;
    // Reset masks every grant so nothing handshakes while rst is high.
    if (!rst) begin
      case (state)
        NORM: begin
          if (req[SRC_LSU])      gnt[SRC_LSU] = 1'b1;
          else if (req[SRC_ALU]) gnt[SRC_ALU] = 1'b1;
        end
        BOOST: begin
          if (req[SRC_ALU])      gnt[SRC_ALU] = 1'b1;
          else if (req[SRC_LSU]) gnt[SRC_LSU] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
    case (state)
      NORM: begin
        if (!req[SRC_ALU] || gnt[SRC_ALU]) begin
          cnt_n = '0;
        end else if (req[SRC_LSU]) begin
          if (cnt_inc == LIM) begin
            state_n = BOOST;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      // The boosted ALU is always granted if valid, so BOOST lasts one cycle.
      BOOST: begin
        state_n = NORM;
        cnt_n   = '0;
      end
      default: begin
        state_n = NORM;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks ALU or LSU result each cycle and registers the
// winner onto the register-bank write port; writes to r0 are suppressed.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUMREGS      = DEF_NUMREGS,
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic        clk_i,
  input logic        rst_i,
  wb_arbiter_if.slave bus
);
  localparam int AW = calc_aw(NUMREGS);

  logic [1:0]           req, gnt;
  logic [AW-1:0]        sel_rd;
  logic [DATAWIDTH-1:0] sel_data;

  assign req[SRC_ALU] = bus.alu_valid_i;
  assign req[SRC_LSU] = bus.lsu_valid_i;

  wb_prio_arb2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req),
    .gnt     (gnt),
    .starved (bus.starved_o)
  );

  assign bus.alu_ready_o = gnt[SRC_ALU];
  assign bus.lsu_ready_o = gnt[SRC_LSU];

  assign sel_rd   = gnt[SRC_ALU] ? bus.alu_rd_i   : bus.lsu_rd_i;
  assign sel_data = gnt[SRC_ALU] ? bus.alu_data_i : bus.lsu_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.we_o    <= 1'b0;
      bus.waddr_o <= '0;
      bus.wdata_o <= '0;
    end else if (|gnt) begin
      bus.we_o    <= (sel_rd != '0);
      bus.waddr_o <= sel_rd;
      bus.wdata_o <= sel_data;
    end else begin
      bus.we_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a loss-counting
// reference model of the ALU/LSU write-back arbitration.
module tb_wb_arbiter;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int LIM = 4;

  typedef struct {
    logic          ar, lr, st, we, chk_ad;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Reference model state: ALU losses in a row, boost pending, next-cycle write.
  int            loss   = 0;
  bit            boost  = 0;
  bit            p_we   = 0;
  bit            p_chk  = 1;
  logic [AW-1:0] p_a    = '0;
  logic [DW-1:0] p_d    = '0;

  wb_arbiter_if #(.AW(AW), .DATAWIDTH(DW)) bus ();

  wb_arbiter #(.NUMREGS(32), .DATAWIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push what the DUT must show in that cycle.
  task automatic cyc(input bit r, input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                     input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.alu_valid_i = av; bus.alu_rd_i = ard; bus.alu_data_i = ad;
    bus.lsu_valid_i = lv; bus.lsu_rd_i = lrd; bus.lsu_data_i = ld;
    if (r)          begin e.ar = 0;  e.lr = 0; end
    else if (boost) begin e.ar = av; e.lr = lv && !av; end
    else            begin e.lr = lv; e.ar = av && !lv; end
    e.st = boost; e.we = p_we; e.a = p_a; e.d = p_d; e.chk_ad = p_we || p_chk;
    q.push_back(e);
    if (r) begin
      p_we = 0; p_a = '0; p_d = '0; p_chk = 1; loss = 0; boost = 0;
    end else begin
      p_chk = 0;
      if (e.ar)      begin p_we = (ard != 0); p_a = ard; p_d = ad; end
      else if (e.lr) begin p_we = (lrd != 0); p_a = lrd; p_d = ld; end
      else           p_we = 0;
      if (boost) begin
        boost = 0; loss = 0;
      end else if (av && lv) begin
        loss++;
        if (loss == LIM) begin boost = 1; loss = 0; end
      end else begin
        loss = 0;
      end
    end
  endtask

  task automatic both(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 1, AW'($urandom_range(1, 63)), $urandom, 1, AW'($urandom_range(1, 63)), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, AW'($urandom), $urandom, 0, AW'($urandom), $urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("alu_ready", 64'(bus.alu_ready_o), 64'(e.ar));
      chk("lsu_ready", 64'(bus.lsu_ready_o), 64'(e.lr));
      chk("starved",   64'(bus.starved_o),   64'(e.st));
      chk("we",        64'(bus.we_o),        64'(e.we));
      if (e.chk_ad) begin
        chk("waddr", 64'(bus.waddr_o), 64'(e.a));
        chk("wdata", 64'(bus.wdata_o), 64'(e.d));
      end
    end
  end

  initial begin
    bus.alu_valid_i = 0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
    bus.lsu_valid_i = 0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0;
    repeat (2) @(posedge clk);
    // Reset held with both sources offering, then release.
    cyc(1, 1, 6'd3, 32'h11, 1, 6'd4, 32'h22);
    cyc(1, 1, 6'd3, 32'h11, 1, 6'd4, 32'h22);
    idle(2);
    // ALU-only write to r5.
    cyc(0, 1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 32'h0);
    idle(2);
    // Continuous contention: LSU x4 then boosted ALU, repeating.
    both(15);
    idle(1);
    // LSU write to r0 handshakes but is never written.
    cyc(0, 0, 6'd7, 32'h0, 1, 6'd0, 32'h1234);
    idle(1);
    // Counter clears when ALU drops out for a cycle.
    both(3);
    cyc(0, 0, 6'd9, 32'h99, 1, 6'd10, 32'hAA);
    both(6);
    idle(1);
    // Reset lands on the edge after a transfer.
    cyc(0, 1, 6'd12, 32'hCAFE, 0, 6'd0, 32'h0);
    cyc(1, 1, 6'd13, 32'hBEEF, 1, 6'd14, 32'hF00D);
    idle(2);
    // Random traffic incl. r0, out-of-range rd and sporadic resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), AW'($urandom), $urandom,
          ($urandom_range(0, 3) != 0), AW'($urandom), $urandom);
    end
    idle(1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUMREGS, default 32, number of architectural registers in the downstream register bank.
REQ-002 The block SHALL have parameter DATAWIDTH, default 32, write-data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive lost ALU arbitrations before the ALU is boosted.
REQ-004 The block SHALL use address width AW = $clog2(NUMREGS)+1 on every register-address port, which is 6 bits at defaults.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have ports alu_valid_i, input, 1 bit; alu_rd_i, input, AW bits; alu_data_i, input, DATAWIDTH bits; together these form the ALU result offer.
REQ-008 The block SHALL have port alu_ready_o, output, 1 bit, ALU result accepted this cycle.
REQ-009 The block SHALL have ports lsu_valid_i, input, 1 bit; lsu_rd_i, input, AW bits; lsu_data_i, input, DATAWIDTH bits; together these form the load-data offer.
REQ-010 The block SHALL have port lsu_ready_o, output, 1 bit, load data accepted this cycle.
REQ-011 The block SHALL have ports we_o, output, 1 bit; waddr_o, output, AW bits; wdata_o, output, DATAWIDTH bits; together these drive the register bank write port.
REQ-012 The block SHALL have port starved_o, output, 1 bit, high while the FSM is in BOOST.

Function
REQ-013 A source transfer SHALL occur in a cycle where its valid and ready are both high.
REQ-014 The ready outputs SHALL be combinational from the valid inputs and FSM state, and a ready output SHALL never be high when its own valid is low.
REQ-015 At most one source SHALL be granted per cycle.
REQ-016 In state NORM, a valid LSU SHALL be granted, and the ALU SHALL be granted only when lsu_valid_i is low.
REQ-017 In state BOOST, a valid ALU SHALL be granted, and the LSU SHALL be granted only when alu_valid_i is low.
REQ-018 The starvation counter SHALL increment by 1 each cycle in NORM where alu_valid_i and lsu_valid_i are both high.
REQ-019 The starvation counter SHALL clear to 0 on any ALU transfer or on any cycle where alu_valid_i is low.
REQ-020 The FSM SHALL move from NORM to BOOST on the edge where the counter would reach STARVE_LIMIT, and the counter SHALL then be cleared.
REQ-021 The FSM SHALL move from BOOST to NORM after exactly one ALU transfer, and SHALL also move from BOOST to NORM if alu_valid_i is low.
REQ-022 BOOST SHALL therefore last exactly one cycle, and with both sources continuously valid the ALU SHALL get 1 of every STARVE_LIMIT+1 grants.
REQ-023 The write outputs SHALL be registered, with a latency of exactly 1 cycle: a transfer at edge N SHALL present we_o/waddr_o/wdata_o during cycle N+1.
REQ-024 A transfer with rd equal to 0 SHALL complete its handshake while we_o stays 0 in the following cycle, since register 0 is never written.
REQ-025 In a cycle with no transfer, we_o SHALL be 0 in the next cycle, and waddr_o/wdata_o SHALL hold their previous values.
REQ-026 rd values greater than or equal to NUMREGS SHALL be passed through unchanged; range checking is not this block's job.
REQ-027 The counter SHALL be $clog2(STARVE_LIMIT+1) bits wide and SHALL saturate at STARVE_LIMIT, never wrapping.

Reset
REQ-028 While rst_i is high at an edge, the block SHALL set we_o=0, waddr_o=0, wdata_o=0, the counter to 0, the FSM to NORM, and starved_o=0.
REQ-029 While rst_i is high, both ready outputs SHALL be forced to 0, so no transfer completes.
REQ-030 A reset asserted while a write is pending in the output register SHALL drop that write, so we_o is 0 in the cycle after reset.

Structure
REQ-031 A shared package wb_pkg SHALL hold the NUMREGS and DATAWIDTH defaults, the AW derivation, and the FSM state enum {NORM, BOOST}.
REQ-032 The priority-select-plus-starvation logic SHALL be one sub-module named wb_prio_arb2, with a 2-request input, a 2-grant output, and the counter and FSM inside it.
REQ-033 The output write register SHALL reside in the top-level module wb_arbiter.

Verification
REQ-034 Reset check: hold rst_i high for 2 cycles with both valids high -> both readys stay 0 and we_o=0; after release, we_o=0 until the first transfer.
REQ-035 Single source: ALU-only with alu_valid_i=1, alu_rd_i=5, alu_data_i=0xDEADBEEF for 1 cycle -> alu_ready_o=1 that cycle; next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; the cycle after, we_o=0.
REQ-036 Priority and boost: both valid continuously with STARVE_LIMIT=4 -> grants follow LSU,LSU,LSU,LSU,ALU repeating, and starved_o is high only on each ALU grant cycle.
REQ-037 Register 0 discard: an LSU transfer with rd=0 and data 0x1234 -> lsu_ready_o=1, and we_o=0 in the next cycle.
REQ-038 Counter clear: both valid for 3 cycles, then alu_valid_i low for 1 cycle, then both valid again -> 4 further LSU grants occur before the ALU grant.
REQ-039 Reset mid-write: a transfer at edge N with rst_i high at edge N+1 -> we_o=0 after edge N+1, and the FSM is in NORM.
